rotate_seq_ctrl: RTL and testbench

Sequencer for a left-rotate register with load/en controls and a DW-bit data input.
- Accepts a command over a valid/ready handshake. A command holds a pattern, a rotate count, a step period and a continuous flag.
- Drives the register's load, en and data inputs: loads the pattern once, then pulses en on a programmable cadence.
- Reports busy, done and remaining steps to the host logic.

---
 rtl/rotate_seq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_rotate_seq_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_seq_ctrl.sv
// rotate_seq_ctrl
// Sequencer for a left-rotate register with load/en controls. A command
// (pattern, rotate count, step period, continuous flag) is accepted over a
// valid/ready handshake. The pattern is loaded once, then en is pulsed
// every period+1 cycles until the count is exhausted, or until abort when
// running continuously.
//
// Ports:
//   clk          clock, all state updates on posedge
//   async_rst    asynchronous active-high reset
//   cmd_valid    command present
//   cmd_ready    controller idle and able to accept a command
//   cmd_pattern  pattern to load into the register
//   cmd_count    number of rotate steps (ignored when cmd_cont=1)
//   cmd_period   idle cycles between steps (0 = step every cycle)
//   cmd_cont     1 = rotate until abort
//   abort        terminate the current command
//   reg_load     register load strobe
//   reg_en       register rotate-enable strobe
//   reg_data     register parallel data (latched pattern)
//   busy         command in progress (LOAD or ROTATE)
//   done         one-cycle pulse on normal completion
//   steps_left   remaining steps of the current command
module rotate_seq_ctrl #(
  parameter int DW = 4,
  parameter int CW = 8,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          async_rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_pattern,
  input  logic [CW-1:0] cmd_count,
  input  logic [PW-1:0] cmd_period,
  input  logic          cmd_cont,
  input  logic          abort,
  output logic          reg_load,
  output logic          reg_en,
  output logic [DW-1:0] reg_data,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] steps_left
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_ROTATE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [DW-1:0] pattern_reg, pattern_next;
  logic [CW-1:0] steps_left_reg, steps_left_next;
  logic [PW-1:0] period_reg, period_next;
  logic          cont_reg, cont_next;
  logic [PW-1:0] presc_reg, presc_next;

  // A step fires on the cycle the prescaler has counted up to the period.
  logic step_hit;
  assign step_hit = (presc_reg == period_reg);

  // State register
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_reg      <= S_IDLE;
      pattern_reg    <= '0;
      steps_left_reg <= '0;
      period_reg     <= '0;
      cont_reg       <= 1'b0;
      presc_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      pattern_reg    <= pattern_next;
      steps_left_reg <= steps_left_next;
      period_reg     <= period_next;
      cont_reg       <= cont_next;
      presc_reg      <= presc_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next      = state_reg;
    pattern_next    = pattern_reg;
    steps_left_next = steps_left_reg;
    period_next     = period_reg;
    cont_next       = cont_reg;
    presc_next      = presc_reg;

    case (state_reg)
      S_IDLE: begin
        // cmd_ready is implied in IDLE, so valid alone is an accept.
        if (cmd_valid) begin
          pattern_next    = cmd_pattern;
          steps_left_next = cmd_count;
          period_next     = cmd_period;
          cont_next       = cmd_cont;
          presc_next      = '0;
          state_next      = S_LOAD;
        end
      end

      S_LOAD: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (!cont_reg && (steps_left_reg == '0)) begin
          state_next = S_DONE;
        end else begin
          presc_next = '0;
          state_next = S_ROTATE;
        end
      end

      S_ROTATE: begin
        // Abort freezes steps_left; the suppressed step is not counted.
        if (abort) begin
          state_next = S_IDLE;
        end else if (step_hit) begin
          presc_next = '0;
          if (!cont_reg) begin
            if (steps_left_reg != '0) begin
              steps_left_next = steps_left_reg - CW'(1);
            end
            if (steps_left_reg <= CW'(1)) begin
              state_next = S_DONE;
            end
          end
        end else begin
          presc_next = presc_reg + PW'(1);
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output decode; abort is the only input allowed to reach the strobes.
  always_comb begin
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    reg_load   = 1'b0;
    reg_en     = 1'b0;
    reg_data   = pattern_reg;
    steps_left = steps_left_reg;

    case (state_reg)
      S_IDLE: begin
        cmd_ready = 1'b1;
      end
      S_LOAD: begin
        busy     = 1'b1;
        reg_load = !abort;
      end
      S_ROTATE: begin
        busy   = 1'b1;
        reg_en = step_hit && !abort;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// Self-checking bench for rotate_seq_ctrl. Expected behaviour of each
// command is computed arithmetically from its timing rules: load in cycle
// 1 after accept, step i at cycle 1 + i*(period+1), done one cycle after
// the last step. A plain left-rotate register is attached to the outputs.
module tb_rotate_seq_ctrl;

  logic       clk = 1'b0;
  logic       async_rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_pattern;
  logic [7:0] cmd_count;
  logic [7:0] cmd_period;
  logic       cmd_cont;
  logic       abort;
  logic       reg_load;
  logic       reg_en;
  logic [3:0] reg_data;
  logic       busy;
  logic       done;
  logic [7:0] steps_left;

  int n_tests = 0;
  int n_fail  = 0;

  // Attached register driven by the controller.
  logic [3:0] shadow = 4'h0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reg_load)    shadow <= reg_data;
    else if (reg_en) shadow <= {shadow[2:0], shadow[3]};
  end

  rotate_seq_ctrl #(.DW(4), .CW(8), .PW(8)) dut (
    .clk        (clk),
    .async_rst  (async_rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_pattern(cmd_pattern),
    .cmd_count  (cmd_count),
    .cmd_period (cmd_period),
    .cmd_cont   (cmd_cont),
    .abort      (abort),
    .reg_load   (reg_load),
    .reg_en     (reg_en),
    .reg_data   (reg_data),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left)
  );

  function automatic logic [3:0] rotl(input logic [3:0] v, input int n);
    logic [7:0] d;
    d = {v, v} << (n % 4);
    return d[7:4];
  endfunction

  // Number of steps scheduled strictly before cycle t.
  function automatic int steps_before(input int t, input int per);
    if (t <= 2) return 0;
    return (t - 2) / (per + 1);
  endfunction

  // Drives one command and checks every cycle until the controller is idle
  // again. abort_at / junk_at = 0 means none; junk_at raises cmd_valid with
  // a different pattern in that cycle (it must be dropped).
  task automatic run_cmd(input logic [3:0] pat, input logic [7:0] cnt,
                         input logic [7:0] per, input bit cont,
                         input int abort_at, input int junk_at);
    int td, last, ns, t_eff, sl_abort;
    bit aborted, is_step;
    logic [16:0] exp_v, got_v;
    logic [7:0] exp_sl;
    td      = cont ? 32'h7fff_ffff : 2 + int'(cnt) * (int'(per) + 1);
    aborted = (abort_at != 0) && (abort_at < td);
    last    = aborted ? abort_at + 1 : td + 1;
    sl_abort = 0;

    @(negedge clk);
    cmd_valid = 1'b1; cmd_pattern = pat; cmd_count = cnt;
    cmd_period = per; cmd_cont = cont; abort = 1'b0;
    #1;
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready pat=%b got=%b exp=1", pat, cmd_ready);
    end

    for (int t = 1; t <= last; t++) begin
      @(negedge clk);
      cmd_valid   = (t == junk_at);
      cmd_pattern = ~pat;
      cmd_count   = cnt + 8'd1;
      abort       = (t == abort_at);
      #1;
      ns = steps_before(t, int'(per));
      if (!cont && ns > int'(cnt)) ns = int'(cnt);
      is_step = (t >= 2) && (((t - 1) % (int'(per) + 1)) == 0) &&
                (cont || ((t - 1) / (int'(per) + 1)) <= int'(cnt));
      exp_sl = cont ? cnt : cnt - 8'(ns);
      if (aborted && t == abort_at) sl_abort = int'(exp_sl);

      if (aborted && t > abort_at)
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'(sl_abort), pat};
      else if (!aborted && t == td + 1)
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, pat};
      else if (!aborted && t == td)
        exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, pat};
      else
        exp_v = {1'b0, 1'b1, (t == 1) && (t != abort_at),
                 is_step && (t != abort_at), 1'b0, exp_sl, pat};

      got_v = {cmd_ready, busy, reg_load, reg_en, done, steps_left, reg_data};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL outs pat=%b cnt=%0d per=%0d cont=%0d t=%0d got(rdy,bsy,ld,en,dn,sl,data)=%b_%b_%b_%b_%b_%0d_%b exp=%b_%b_%b_%b_%b_%0d_%b",
                 pat, cnt, per, cont, t, got_v[16], got_v[15], got_v[14], got_v[13],
                 got_v[12], got_v[11:4], got_v[3:0], exp_v[16], exp_v[15], exp_v[14],
                 exp_v[13], exp_v[12], exp_v[11:4], exp_v[3:0]);
      end

      // Register contents reflect steps applied before this cycle.
      if (t >= 2 && !(aborted && abort_at == 1)) begin
        t_eff = (aborted && t > abort_at) ? abort_at : t;
        ns = steps_before(t_eff, int'(per));
        if (!cont && ns > int'(cnt)) ns = int'(cnt);
        n_tests++;
        if (shadow !== rotl(pat, ns)) begin
          n_fail++;
          $display("FAIL register pat=%b t=%0d got=%b exp=%b", pat, t, shadow, rotl(pat, ns));
        end
      end
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
    $display("[TB] cmd pat=%b cnt=%0d per=%0d cont=%0d abort_at=%0d junk_at=%0d checked",
             pat, cnt, per, cont, abort_at, junk_at);
  endtask

  task automatic test_reset();
    async_rst = 1'b1; cmd_valid = 1'b0; cmd_pattern = 4'h0; cmd_count = 8'd0;
    cmd_period = 8'd0; cmd_cont = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({cmd_ready, busy, reg_load, reg_en, done, steps_left, reg_data} !== {5'b10000, 8'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_outs got=%b_%b_%b_%b_%b_%0d_%b exp=1_0_0_0_0_0_0000",
               cmd_ready, busy, reg_load, reg_en, done, steps_left, reg_data);
    end
    async_rst = 1'b0;
    $display("[TB] reset checked");
  endtask

  task automatic test_basic();        run_cmd(4'b0001, 8'd3, 8'd0, 1'b0, 0, 0); endtask
  task automatic test_period();       run_cmd(4'b1001, 8'd2, 8'd2, 1'b0, 0, 0); endtask
  task automatic test_zero_count();   run_cmd(4'b1010, 8'd0, 8'd0, 1'b0, 0, 0); endtask
  task automatic test_cont_abort();   run_cmd(4'b0001, 8'd9, 8'd0, 1'b1, 8, 0); endtask
  task automatic test_cmd_while_busy(); run_cmd(4'b0110, 8'd5, 8'd0, 1'b0, 0, 3); endtask
  task automatic test_max_count();    run_cmd(4'b0011, 8'd255, 8'd0, 1'b0, 0, 0); endtask
  task automatic test_abort_in_load(); run_cmd(4'b1100, 8'd4, 8'd1, 1'b0, 1, 0); endtask
  task automatic test_abort_in_done(); run_cmd(4'b0101, 8'd2, 8'd1, 1'b0, 6, 6); endtask

  task automatic test_async_reset();
    logic [3:0] held;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_pattern = 4'b0011; cmd_count = 8'd5;
    cmd_period = 8'd0; cmd_cont = 1'b0; abort = 1'b0;
    repeat (3) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    // Cycle 3 after accept: ROTATE with a step in progress.
    #1;
    n_tests++;
    if ({busy, reg_en} !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_reset_rotate got(bsy,en)=%b%b exp=11", busy, reg_en);
    end
    held = shadow;
    #1 async_rst = 1'b1;
    #1;
    n_tests++;
    if ({cmd_ready, busy, reg_load, reg_en, done, steps_left} !== {5'b10000, 8'd0}) begin
      n_fail++;
      $display("FAIL async_reset_outs got=%b_%b_%b_%b_%b_%0d exp=1_0_0_0_0_0",
               cmd_ready, busy, reg_load, reg_en, done, steps_left);
    end
    @(negedge clk);
    async_rst = 1'b0;
    #1;
    n_tests++;
    if (shadow !== held) begin
      n_fail++;
      $display("FAIL reg_kept_after_reset got=%b exp=%b", shadow, held);
    end
    $display("[TB] async reset mid-rotate checked");
    run_cmd(4'b1000, 8'd2, 8'd1, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    logic [3:0] pat;
    logic [7:0] cnt, per;
    bit cont;
    int ab, jk, td;
    for (int i = 0; i < 25; i++) begin
      pat  = 4'($urandom);
      cnt  = 8'($urandom_range(0, 6));
      per  = 8'($urandom_range(0, 3));
      cont = ($urandom_range(0, 3) == 0);
      td   = 2 + int'(cnt) * (int'(per) + 1);
      if (cont) ab = $urandom_range(1, 20);
      else      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, td) : 0;
      jk = $urandom_range(0, 1) ? $urandom_range(1, (ab != 0) ? ab : td) : 0;
      run_cmd(pat, cnt, per, cont, ab, jk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_period();
    test_zero_count();
    test_cont_abort();
    test_cmd_while_busy();
    test_max_count();
    test_abort_in_load();
    test_abort_in_done();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
